rc4_phase_sequencer: RTL and testbench
======================================

// Module: rc4_phase_sequencer
// PURPOSE
//  Sequences the RC4 engines init -> ksa -> prga and arbitrates the single-port S memory between them.
//  Sits between the top-level/cracker control and the engines.
//  Latches the key, launches each engine via en/rdy and owns the S-memory bus mux.
//  Enforces a 1-cycle idle gap between phases and a per-phase watchdog timeout.
// PARAMETERS
//  KEY_W    24    key width in bits, latched and driven to ksa/prga
//  TIMEOUT  4096  max cycles per phase, from launch to engine completion; must be >= 4
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      synchronous active-low reset
//  start        in   1      request run; accepted only when rdy=1
//  key_in       in   KEY_W  key, sampled on accepted start
//  rdy          out  1      1 in S_IDLE, S_DONE, S_ERR (can accept start)
//  done         out  1      1-cycle pulse on entry to S_DONE
//  err          out  1      sticky timeout flag; cleared on next accepted start
//  phase        out  2      current phase_t (INIT=0, KSA=1, PRGA=2)
//  key          out  KEY_W  latched key to ksa/prga
//  init_en/ksa_en/prga_en        out 1  one-cycle launch pulses
//  init_rdy/ksa_rdy/prga_rdy     in  1  engine idle/finished
//  {init,ksa,prga}_addr          in  8  engine S-memory address
//  {init,ksa,prga}_wrdata        in  8  engine write data
//  {init,ksa,prga}_wren          in  1  engine write enable
//  mem_addr     out  8  to s_mem
//  mem_wrdata   out  8  to s_mem
//  mem_wren     out  1  to s_mem
//  mem_rddata   in   8  from s_mem; ksa_rddata/prga_rddata driven from it unconditionally
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge), effective the same edge, including mid-run:
//   state=S_IDLE, phase=INIT, key=0, err=0, done=0.
//   All *_en=0; mem_addr/mem_wrdata=0; mem_wren=0.
//  States: S_IDLE, S_LAUNCH, S_ACK, S_RUN, S_GAP, S_DONE, S_ERR.
//  IDLE/DONE/ERR with start=1:
//   key<=key_in, err<=0, phase<=INIT, -> S_LAUNCH.
//   start while rdy=0 is ignored (no queuing).
//  LAUNCH:
//   Wait for the current phase's engine rdy=1.
//   Then assert that engine's en for exactly 1 cycle, clear wdog, -> S_ACK.
//  ACK:
//   Wait for engine rdy=0 (engine started), -> S_RUN.
//  RUN:
//   Wait for engine rdy=1.
//   If phase=PRGA -> S_DONE, else -> S_GAP.
//  GAP:
//   Exactly 1 cycle with the bus idle (lets an in-flight s_mem read retire).
//   phase<=phase+1, -> S_LAUNCH.
//  Watchdog:
//   Counter is cleared on the LAUNCH->ACK transition and increments every cycle in ACK/RUN.
//   Reaching TIMEOUT-1 -> S_ERR with err<=1.
//   Timeout takes priority over an rdy seen in the same cycle.
//  Bus mux (combinational on state, phase):
//   In LAUNCH/ACK/RUN, mem_* = the selected engine's addr/wrdata/wren.
//   Otherwise mem_*=0 and mem_wren=0.
//   A non-selected engine's wren never reaches memory.
//  done asserts the cycle state first equals S_DONE only; remains 0 while held in S_DONE.
//  phase holds its last value in S_DONE/S_ERR.
//  Minimum run latency: start to done = 3 phases x (LAUNCH+ACK+RUN) + 2 GAP cycles.
// STRUCTURE
//  rc4_pkg: phase_t (2b enum), seq_state_t enum, KEY_W_DEFAULT, S_ADDR_W=8, S_DATA_W=8.
//  Sub-module rc4_smem_mux:
//   Pure combinational 3:1 bus select with idle override.
//   Instantiated once; reusable by future tops.
//  Watchdog counter width = $clog2(TIMEOUT).
// TESTING
//  1. Stub engines, each busy 5 cycles; start, key_in=24'h00033C
//     -> init_en, ksa_en, prga_en each pulse once, in order.
//     -> key=24'h00033C; done pulses once; err=0.
//  2. Assert init_wren=1, addr=8'h55 while phase=KSA
//     -> mem_wren follows ksa_wren only; mem_wren=0 in every GAP cycle.
//  3. ksa stub never returns rdy, TIMEOUT=16
//     -> S_ERR 16 cycles after ksa_en; err=1; rdy=1.
//     -> Then start -> err=0, phase=INIT, new run.
//  4. rst_n=0 for 1 cycle mid-KSA
//     -> next cycle all en=0, mem_wren=0, phase=INIT, rdy=1, no done pulse.
//  5. start held high continuously across a full run
//     -> second run launches the cycle after done.
//     -> start pulses while rdy=0 ignored (key unchanged).

Source files
------------

// File: rtl/rc4_phase_sequencer_pkg.sv
// Shared types and constants for the RC4 phase sequencer and its S-memory bus mux.
package rc4_phase_sequencer_pkg;

  localparam int KEY_W_DEFAULT = 24;
  localparam int S_ADDR_W      = 8;
  localparam int S_DATA_W      = 8;

  typedef enum logic [1:0] {
    PH_INIT = 2'd0,
    PH_KSA  = 2'd1,
    PH_PRGA = 2'd2
  } phase_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_ACK    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // The S-memory bus belongs to an engine only while its phase is in flight.
  function automatic logic bus_active(input logic [2:0] st);
    return (st == S_LAUNCH) || (st == S_ACK) || (st == S_RUN);
  endfunction

endpackage

// File: rtl/rc4_phase_sequencer_if.sv
// Engine handshake and S-memory bus bundle between the sequencer and the init/ksa/prga engines.
interface rc4_phase_sequencer_if;
  import rc4_phase_sequencer_pkg::*;

  logic                init_en,     ksa_en,     prga_en;
  logic                init_rdy,    ksa_rdy,    prga_rdy;
  logic [S_ADDR_W-1:0] init_addr,   ksa_addr,   prga_addr;
  logic [S_DATA_W-1:0] init_wrdata, ksa_wrdata, prga_wrdata;
  logic                init_wren,   ksa_wren,   prga_wren;
  logic [S_ADDR_W-1:0] mem_addr;
  logic [S_DATA_W-1:0] mem_wrdata;
  logic                mem_wren;
  logic [S_DATA_W-1:0] mem_rddata;
  logic [S_DATA_W-1:0] ksa_rddata,  prga_rddata;

  modport master (
    output init_en, ksa_en, prga_en,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output mem_addr, mem_wrdata, mem_wren,
    input  mem_rddata,
    output ksa_rddata, prga_rddata
  );

  modport slave (
    input  init_en, ksa_en, prga_en,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  mem_addr, mem_wrdata, mem_wren,
    output mem_rddata,
    input  ksa_rddata, prga_rddata
  );

endinterface

// File: rtl/rc4_phase_sequencer_smem_mux.sv
// 3:1 S-memory bus select with an idle override that forces the bus to zero.
module rc4_phase_sequencer_smem_mux
  import rc4_phase_sequencer_pkg::*;
(
  input  logic                active_i,
  input  phase_t              sel_i,
  input  logic [S_ADDR_W-1:0] init_addr_i,
  input  logic [S_DATA_W-1:0] init_wrdata_i,
  input  logic                init_wren_i,
  input  logic [S_ADDR_W-1:0] ksa_addr_i,
  input  logic [S_DATA_W-1:0] ksa_wrdata_i,
  input  logic                ksa_wren_i,
  input  logic [S_ADDR_W-1:0] prga_addr_i,
  input  logic [S_DATA_W-1:0] prga_wrdata_i,
  input  logic                prga_wren_i,
  output logic [S_ADDR_W-1:0] mem_addr_o,
  output logic [S_DATA_W-1:0] mem_wrdata_o,
  output logic                mem_wren_o
);

  always_comb begin
    mem_addr_o   = '0;
    mem_wrdata_o = '0;
    mem_wren_o   = 1'b0;
    if (active_i) begin
      case (sel_i)
        PH_INIT: begin
          mem_addr_o   = init_addr_i;
          mem_wrdata_o = init_wrdata_i;
          mem_wren_o   = init_wren_i;
        end
        PH_KSA: begin
          mem_addr_o   = ksa_addr_i;
          mem_wrdata_o = ksa_wrdata_i;
          mem_wren_o   = ksa_wren_i;
        end
        PH_PRGA: begin
          mem_addr_o   = prga_addr_i;
          mem_wrdata_o = prga_wrdata_i;
          mem_wren_o   = prga_wren_i;
        end
        default: begin
          mem_addr_o   = '0;
          mem_wrdata_o = '0;
          mem_wren_o   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs the RC4 init -> ksa -> prga engines in order, owns the shared S-memory bus
// and aborts a phase that overruns its watchdog.
module rc4_phase_sequencer
  import rc4_phase_sequencer_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEFAULT,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [KEY_W-1:0]  key_in_i,
  output logic              rdy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        phase_o,
  output logic [KEY_W-1:0]  key_o,
  rc4_phase_sequencer_if.master eng
);

  localparam int WDOG_W = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [KEY_W-1:0]  key_q,   key_d;
  logic              err_q,   err_d;
  logic              done_q,  done_d;
  logic [WDOG_W-1:0] wdog_q,  wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              sel_rdy;
  logic              launch;

  assign wdog_inc = wdog_q + WDOG_W'(1);

  always_comb begin
    sel_rdy = 1'b0;
    case (phase_q)
      PH_INIT: sel_rdy = eng.init_rdy;
      PH_KSA:  sel_rdy = eng.ksa_rdy;
      PH_PRGA: sel_rdy = eng.prga_rdy;
      default: sel_rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    key_d   = key_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          key_d   = key_in_i;
          err_d   = 1'b0;
          phase_d = PH_INIT;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (sel_rdy) begin
          launch  = 1'b1;
          wdog_d  = '0;
          state_d = S_ACK;
        end
      end
      S_ACK, S_RUN: begin
        // A timeout wins even if the engine reports completion in the same cycle.
        if (wdog_inc == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_inc;
          if (state_q == S_ACK && !sel_rdy) begin
            state_d = S_RUN;
          end else if (state_q == S_RUN && sel_rdy) begin
            state_d = (phase_q == PH_PRGA) ? S_DONE : S_GAP;
          end
        end
      end
      S_GAP: begin
        phase_d = phase_t'(phase_q + 2'd1);
        state_d = S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_INIT;
      key_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      key_q   <= key_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wdog_q  <= wdog_d;
    end
  end

  assign rdy_o   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign phase_o = phase_q;
  assign key_o   = key_q;

  assign eng.init_en = launch && (phase_q == PH_INIT);
  assign eng.ksa_en  = launch && (phase_q == PH_KSA);
  assign eng.prga_en = launch && (phase_q == PH_PRGA);

  assign eng.ksa_rddata  = eng.mem_rddata;
  assign eng.prga_rddata = eng.mem_rddata;

  rc4_phase_sequencer_smem_mux u_smem_mux (
    .active_i      (bus_active(state_q)),
    .sel_i         (phase_q),
    .init_addr_i   (eng.init_addr),
    .init_wrdata_i (eng.init_wrdata),
    .init_wren_i   (eng.init_wren),
    .ksa_addr_i    (eng.ksa_addr),
    .ksa_wrdata_i  (eng.ksa_wrdata),
    .ksa_wren_i    (eng.ksa_wren),
    .prga_addr_i   (eng.prga_addr),
    .prga_wrdata_i (eng.prga_wrdata),
    .prga_wren_i   (eng.prga_wren),
    .mem_addr_o    (eng.mem_addr),
    .mem_wrdata_o  (eng.mem_wrdata),
    .mem_wren_o    (eng.mem_wren)
  );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer with 5-cycle stub engines and a 16-cycle watchdog.
module tb_rc4_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] keyIn;
  logic        rdy, done, err;
  logic [1:0]  phase;
  logic [23:0] key;
  logic [3:0]  initCnt, ksaCnt, prgaCnt;
  bit          ksaHang = 1'b0;
  int          passCount = 0;
  int          totalCount = 0;

  rc4_phase_sequencer_if eng ();

  rc4_phase_sequencer #(.KEY_W(24), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .key_in_i (keyIn),
    .rdy_o    (rdy),
    .done_o   (done),
    .err_o    (err),
    .phase_o  (phase),
    .key_o    (key),
    .eng      (eng)
  );

  always #5 clk = ~clk;

  // Stub engines: busy for 5 cycles after each launch pulse; ksa can be frozen busy.
  always @(posedge clk) begin
    if (!rst_n) begin
      initCnt <= '0;
      ksaCnt  <= '0;
      prgaCnt <= '0;
    end else begin
      if (eng.init_en) initCnt <= 4'd5;
      else if (initCnt != 0) initCnt <= initCnt - 4'd1;
      if (eng.ksa_en) ksaCnt <= 4'd5;
      else if (ksaCnt != 0 && !ksaHang) ksaCnt <= ksaCnt - 4'd1;
      if (eng.prga_en) prgaCnt <= 4'd5;
      else if (prgaCnt != 0) prgaCnt <= prgaCnt - 4'd1;
    end
  end

  assign eng.init_rdy = (initCnt == 0);
  assign eng.ksa_rdy  = (ksaCnt == 0);
  assign eng.prga_rdy = (prgaCnt == 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic [23:0] k);
    start = st;
    keyIn = k;
  endtask

  initial begin
    int initC, ksaC, prgaC, doneC, initN, ksaN, prgaN, doneN, errC;
    logic       expWren;
    logic [7:0] expAddr, expData;

    rst_n = 1'b0;
    applyStimulus(1'b0, 24'h0);
    eng.init_addr = 8'h55; eng.init_wrdata = 8'h11; eng.init_wren = 1'b1;
    eng.ksa_addr  = 8'hAA; eng.ksa_wrdata  = 8'h22; eng.ksa_wren  = 1'b1;
    eng.prga_addr = 8'h0F; eng.prga_wrdata = 8'h33; eng.prga_wren = 1'b0;
    eng.mem_rddata = 8'h3C;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rstRdy",     rdy, 1);
    checkOutput("rstDone",    done, 0);
    checkOutput("rstErr",     err, 0);
    checkOutput("rstPhase",   phase, 0);
    checkOutput("rstKey",     key, 0);
    checkOutput("rstMemWren", eng.mem_wren, 0);
    checkOutput("rstMemAddr", eng.mem_addr, 0);
    checkOutput("rstEns",     {eng.init_en, eng.ksa_en, eng.prga_en}, 0);
    checkOutput("ksaRddata",  eng.ksa_rddata, 8'h3C);
    checkOutput("prgaRddata", eng.prga_rddata, 8'h3C);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full run with bus ownership per cycle");
    applyStimulus(1'b1, 24'h00033C);
    initC = 0; ksaC = 0; prgaC = 0; doneC = 0;
    initN = 0; ksaN = 0; prgaN = 0; doneN = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (eng.init_en) begin initN++; if (initN == 1) initC = c; end
      if (eng.ksa_en)  begin ksaN++;  if (ksaN == 1)  ksaC = c;  end
      if (eng.prga_en) begin prgaN++; if (prgaN == 1) prgaC = c; end
      if (done)        begin doneN++; if (doneN == 1) doneC = c; end
      expWren = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
      expAddr = (c >= 1 && c <= 7)   ? 8'h55 :
                (c >= 9 && c <= 15)  ? 8'hAA :
                (c >= 17 && c <= 23) ? 8'h0F : 8'h00;
      expData = (c >= 1 && c <= 7)   ? 8'h11 :
                (c >= 9 && c <= 15)  ? 8'h22 :
                (c >= 17 && c <= 23) ? 8'h33 : 8'h00;
      checkOutput($sformatf("memWren@%0d", c), eng.mem_wren, expWren);
      checkOutput($sformatf("memAddr@%0d", c), eng.mem_addr, expAddr);
      checkOutput($sformatf("memData@%0d", c), eng.mem_wrdata, expData);
      if (c == 1)  checkOutput("rdyBusy", rdy, 0);
      if (c == 5)  checkOutput("phaseInit", phase, 0);
      if (c == 12) checkOutput("phaseKsa", phase, 1);
      if (c == 20) checkOutput("phasePrga", phase, 2);
    end
    checkOutput("initEnCycle", initC, 1);
    checkOutput("ksaEnCycle",  ksaC, 9);
    checkOutput("prgaEnCycle", prgaC, 17);
    checkOutput("enCounts",    {initN[7:0], ksaN[7:0], prgaN[7:0]}, 24'h010101);
    checkOutput("doneCycle",   doneC, 24);
    checkOutput("doneCount",   doneN, 1);
    checkOutput("runKey",      key, 24'h00033C);
    checkOutput("runErr",      err, 0);
    checkOutput("donePhase",   phase, 2);
    checkOutput("doneRdy",     rdy, 1);

    $display("[TB] ksa watchdog timeout");
    ksaHang = 1'b1;
    applyStimulus(1'b1, 24'h0ABCDE);
    ksaC = 0; errC = 0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (eng.ksa_en && ksaC == 0) ksaC = c;
      if (err && errC == 0) errC = c;
    end
    checkOutput("hangKsaEn", ksaC, 9);
    checkOutput("errCycle",  errC, 25);
    checkOutput("errFlag",   err, 1);
    checkOutput("errRdy",    rdy, 1);
    checkOutput("errPhase",  phase, 1);
    checkOutput("errDone",   done, 0);
    ksaHang = 1'b0;
    applyStimulus(1'b1, 24'h000777);
    @(negedge clk);
    start = 1'b0;
    checkOutput("restartErr",   err, 0);
    checkOutput("restartPhase", phase, 0);
    checkOutput("restartInit",  eng.init_en, 1);
    checkOutput("restartKey",   key, 24'h000777);
    doneN = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) doneN++;
    end
    checkOutput("restartDone", doneN, 1);

    $display("[TB] reset during ksa");
    applyStimulus(1'b1, 24'h012345);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checkOutput("preRstPhase", phase, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstEns",   {eng.init_en, eng.ksa_en, eng.prga_en}, 0);
    checkOutput("midRstWren",  eng.mem_wren, 0);
    checkOutput("midRstPhase", phase, 0);
    checkOutput("midRstRdy",   rdy, 1);
    checkOutput("midRstKey",   key, 0);
    rst_n = 1'b1;
    doneN = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) doneN++;
    end
    checkOutput("midRstNoDone", doneN, 0);

    $display("[TB] start held high across a run");
    applyStimulus(1'b1, 24'h0000AA);
    initN = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 5) keyIn = 24'h0000BB;
      if (c >= 2 && c <= 24 && eng.init_en) initN++;
      if (c == 1)  checkOutput("heldFirstInit", eng.init_en, 1);
      if (c == 20) checkOutput("heldKeyKept", key, 24'h0000AA);
      if (c == 24) checkOutput("heldDone", done, 1);
      if (c == 25) begin
        checkOutput("heldRelaunch", eng.init_en, 1);
        checkOutput("heldNewKey", key, 24'h0000BB);
        checkOutput("heldDoneOff", done, 0);
      end
    end
    checkOutput("heldNoReaccept", initN, 0);
    start = 1'b0;

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
